// File: rtl/offset_load_ctrl_pkg.sv
// rtl/offset_load_ctrl_pkg.sv - shared widths, beat ratio and FSM encoding for the offset table loader
package offset_load_ctrl_pkg;

  localparam int HBM_AWIDTH_DEF      = 28;
  localparam int CNT_WIDTH_DEF       = 20;
  localparam int MAX_OUTSTANDING_DEF = 64;
  localparam int OUT_WIDTH_DEF       = 7;
  localparam int CORE_NUM_DEF        = 16;
  localparam int CLEAR_CYCLES_DEF    = 2;

  // One loffset beat plus one roffset beat per URAM entry.
  localparam int BEATS_PER_ENTRY = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } load_state_e;

endpackage

// File: rtl/offset_load_credit.sv
// rtl/offset_load_credit.sv - outstanding-beat credit counter with limit compare and sticky underflow flag
module offset_load_credit #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int OUT_WIDTH       = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  input  logic check,
  output logic room,
  output logic accepted,
  output logic underflow
);

  logic [OUT_WIDTH-1:0] count;
  logic                 empty;

  assign empty    = (count == '0);
  assign room     = (count < OUT_WIDTH'(MAX_OUTSTANDING));
  // A beat with nothing outstanding is dropped rather than letting the counter wrap.
  assign accepted = dec && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else begin
        count <= count + OUT_WIDTH'(inc) - OUT_WIDTH'(accepted);
      end
      if (check && dec && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/offset_load_ctrl.sv
// rtl/offset_load_ctrl.sv - bulk load of the vertex-offset table from one HBM pseudo channel into the core URAMs
module offset_load_ctrl
  import offset_load_ctrl_pkg::*;
#(
  parameter int HBM_AWIDTH      = HBM_AWIDTH_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int OUT_WIDTH       = OUT_WIDTH_DEF,
  parameter int CORE_NUM        = CORE_NUM_DEF,
  parameter int CLEAR_CYCLES    = CLEAR_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [HBM_AWIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-2:0]  entry_num,
  output logic [HBM_AWIDTH-1:0] hbm_addr,
  output logic                  hbm_addr_valid,
  input  logic                  hbm_full,
  input  logic                  hbm_data_valid,
  output logic                  uram_rst,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  protocol_err,
  input  logic [CORE_NUM-1:0]   core_rst_in,
  output logic [CORE_NUM-1:0]   core_rst_out
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  load_state_e           state;
  logic [CLR_W-1:0]      clr_cnt;
  logic [HBM_AWIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  total_beats;
  logic [CNT_WIDTH-1:0]  issued;
  logic [CNT_WIDTH-1:0]  received;
  logic                  room;
  logic                  beat_ok;
  logic                  accept;
  logic                  issue;
  logic                  check;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign issue  = (state == ST_FETCH) && !hbm_full && room && (issued < total_beats);
  // Beats landing in IDLE are leftovers from an aborted load and are silently dropped.
  assign check  = (state != ST_IDLE);

  offset_load_credit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .OUT_WIDTH      (OUT_WIDTH)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .inc      (issue),
    .dec      (hbm_data_valid),
    .check    (check),
    .room     (room),
    .accepted (beat_ok),
    .underflow(protocol_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      clr_cnt        <= '0;
      base_q         <= '0;
      total_beats    <= '0;
      issued         <= '0;
      received       <= '0;
      hbm_addr       <= '0;
      hbm_addr_valid <= 1'b0;
      uram_rst       <= 1'b0;
      load_busy      <= 1'b0;
      load_done      <= 1'b0;
      core_rst_out   <= '1;
    end else begin
      // Cores stay in reset until the table is resident, so no offset read races a load write.
      core_rst_out   <= core_rst_in | {CORE_NUM{~load_done}};
      hbm_addr_valid <= issue;
      if (issue) begin
        hbm_addr <= base_q + HBM_AWIDTH'(issued);
        issued   <= issued + CNT_WIDTH'(1);
      end
      if (beat_ok) begin
        received <= received + CNT_WIDTH'(1);
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            base_q      <= base_addr;
            total_beats <= CNT_WIDTH'(entry_num) * CNT_WIDTH'(BEATS_PER_ENTRY);
            issued      <= '0;
            received    <= '0;
            clr_cnt     <= '0;
            uram_rst    <= 1'b1;
            load_busy   <= 1'b1;
            load_done   <= 1'b0;
            state       <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
            uram_rst <= 1'b0;
            clr_cnt  <= '0;
            if (total_beats == '0) begin
              load_busy <= 1'b0;
              load_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_FETCH;
            end
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        ST_FETCH: begin
          if (issue && ((issued + CNT_WIDTH'(1)) == total_beats)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (beat_ok && ((received + CNT_WIDTH'(1)) == total_beats)) begin
            load_busy <= 1'b0;
            load_done <= 1'b1;
            state     <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_offset_load_ctrl.sv
// tb/tb_offset_load_ctrl.sv - directed vector bench for offset_load_ctrl
module tb_offset_load_ctrl;

  localparam int AW = 28;
  localparam int CW = 20;
  localparam int CN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_a, full_a, dv_a, av_a, uram_a, busy_a, done_a, err_a;
  logic [AW-1:0] base_a, addr_a;
  logic [CW-2:0] entry_a;
  logic [CN-1:0] cin_a, cout_a;

  logic          start_b, full_b, dv_b, av_b, uram_b, busy_b, done_b, err_b;
  logic [AW-1:0] base_b, addr_b;
  logic [CW-2:0] entry_b;
  logic [CN-1:0] cin_b, cout_b;

  offset_load_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a), .entry_num(entry_a),
    .hbm_addr(addr_a), .hbm_addr_valid(av_a), .hbm_full(full_a), .hbm_data_valid(dv_a),
    .uram_rst(uram_a), .load_busy(busy_a), .load_done(done_a), .protocol_err(err_a),
    .core_rst_in(cin_a), .core_rst_out(cout_a)
  );

  offset_load_ctrl #(.MAX_OUTSTANDING(4), .OUT_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b), .entry_num(entry_b),
    .hbm_addr(addr_b), .hbm_addr_valid(av_b), .hbm_full(full_b), .hbm_data_valid(dv_b),
    .uram_rst(uram_b), .load_busy(busy_b), .load_done(done_b), .protocol_err(err_b),
    .core_rst_in(cin_b), .core_rst_out(cout_b)
  );

  typedef struct {
    logic          start;
    logic          dv;
    logic          av;
    logic [AW-1:0] addr;
    logic          uram;
    logic          busy;
    logic          done;
    logic [CN-1:0] cout;
  } vec_t;

  vec_t vecs[17];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic d, input logic v, input logic [AW-1:0] a,
                              input logic u, input logic b, input logic dn, input logic [CN-1:0] co);
    vec_t r;
    r.start = s; r.dv = d; r.av = v; r.addr = a;
    r.uram = u; r.busy = b; r.done = dn; r.cout = co;
    return r;
  endfunction

  // Starts a load on dut_a, returns each beat two cycles after its address, optionally pokes start mid-load.
  task automatic run_a(input logic [AW-1:0] base, input logic [CW-2:0] entry, input bit alt_full,
                       input int poke_cyc, output int n_addr, output int n_bad, output int n_viol,
                       output int n_uram, output bit timed_out);
    logic [2:0] pipe;
    logic       prev_full;
    n_addr = 0; n_bad = 0; n_viol = 0; n_uram = 0; timed_out = 1'b1; pipe = '0;
    base_a = base; entry_a = entry; start_a = 1'b1; full_a = 1'b0; dv_a = 1'b0;
    tick();
    start_a = 1'b0;
    if (uram_a) n_uram++;
    for (int c = 0; c < 400; c++) begin
      full_a = alt_full ? c[0] : 1'b0;
      dv_a = pipe[0];
      if (c == poke_cyc) begin
        start_a = 1'b1; base_a = base ^ AW'('h800); entry_a = 1;
      end
      prev_full = full_a;
      tick();
      start_a = 1'b0;
      if (uram_a) n_uram++;
      if (av_a) begin
        if (prev_full) n_viol++;
        if (addr_a !== base + AW'(n_addr)) n_bad++;
        n_addr++;
      end
      pipe = {av_a, pipe[2:1]};
      if (done_a) begin
        timed_out = 1'b0;
        break;
      end
    end
    full_a = 1'b0; dv_a = 1'b0;
  endtask

  initial begin
    int n_addr, n_bad, n_viol, n_uram, n, n2, ret, gaps;
    bit to, seen;

    vecs[0] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 16'hffff);
    vecs[1] = mk(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 16'hffff);
    vecs[2] = mk(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 16'hffff);
    for (int i = 3; i <= 10; i++)
      vecs[i] = mk(1'b0, (i >= 7), 1'b1, AW'('h100 + i - 3), 1'b0, 1'b1, 1'b0, 16'hffff);
    for (int i = 11; i <= 13; i++)
      vecs[i] = mk(1'b0, 1'b1, 1'b0, AW'('h107), 1'b0, 1'b1, 1'b0, 16'hffff);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, AW'('h107), 1'b0, 1'b0, 1'b1, 16'hffff);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, AW'('h107), 1'b0, 1'b0, 1'b1, 16'h00a5);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, AW'('h107), 1'b0, 1'b0, 1'b1, 16'h00a5);

    rst = 1'b1;
    start_a = 1'b0; base_a = '0; entry_a = '0; full_a = 1'b0; dv_a = 1'b0; cin_a = 16'h00a5;
    start_b = 1'b0; base_b = '0; entry_b = '0; full_b = 1'b0; dv_b = 1'b0; cin_b = 16'h0000;
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", 64'({av_a, addr_a, uram_a, busy_a, done_a, err_a, cout_a}),
        64'({1'b0, AW'(0), 1'b0, 1'b0, 1'b0, 1'b0, 16'hffff}));

    dv_a = 1'b1; tick(); dv_a = 1'b0; tick();
    chk("idle_beat_no_err", 64'(err_a), 64'(0));

    base_a = AW'('h100); entry_a = 4;
    for (int i = 0; i < 17; i++) begin
      start_a = vecs[i].start;
      dv_a = vecs[i].dv;
      tick();
      chk($sformatf("nominal[%0d]", i), 64'({av_a, addr_a, uram_a, busy_a, done_a, cout_a}),
          64'({vecs[i].av, vecs[i].addr, vecs[i].uram, vecs[i].busy, vecs[i].done, vecs[i].cout}));
    end
    start_a = 1'b0; dv_a = 1'b0;
    chk("nominal_no_err", 64'(err_a), 64'(0));

    run_a(AW'('hffffffc), 8, 1'b1, -1, n_addr, n_bad, n_viol, n_uram, to);
    chk("bp_addr_count", 64'(n_addr), 64'(16));
    chk("bp_addr_seq_wrap", 64'(n_bad), 64'(0));
    chk("bp_issue_after_full", 64'(n_viol), 64'(0));
    chk("bp_uram_cycles", 64'(n_uram), 64'(2));
    chk("bp_done", 64'(to), 64'(0));

    run_a(AW'('h200), 4, 1'b0, 3, n_addr, n_bad, n_viol, n_uram, to);
    chk("poke_addr_count", 64'(n_addr), 64'(8));
    chk("poke_addr_seq", 64'(n_bad), 64'(0));
    chk("poke_done", 64'(to), 64'(0));

    run_a(AW'('h500), 0, 1'b0, -1, n_addr, n_bad, n_viol, n_uram, to);
    chk("zero_addr_count", 64'(n_addr), 64'(0));
    chk("zero_uram_cycles", 64'(n_uram), 64'(2));
    chk("zero_done", 64'(to), 64'(0));
    chk("zero_busy", 64'(busy_a), 64'(0));

    chk("pre_stray_err", 64'(err_a), 64'(0));
    dv_a = 1'b1; tick(); dv_a = 1'b0;
    chk("stray_done_err", 64'(err_a), 64'(1));

    // Credit limit of 4 with no returns, then one return frees exactly one slot.
    base_b = AW'('h40); entry_b = 8; start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0; n_bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (av_b) begin
        if (addr_b !== AW'('h40 + n)) n_bad++;
        n++;
      end
    end
    chk("credit_issued", 64'(n), 64'(4));
    chk("credit_stall", 64'(av_b), 64'(0));
    dv_b = 1'b1; tick(); dv_b = 1'b0;
    n2 = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (av_b) begin
        if (addr_b !== AW'('h40 + n)) n_bad++;
        n++; n2++;
      end
    end
    chk("credit_one_more", 64'(n2), 64'(1));

    ret = 1; gaps = 0; seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      dv_b = (n - ret) > 0;
      if (dv_b) ret++;
      tick();
      if (av_b) begin
        if (addr_b !== AW'('h40 + n)) n_bad++;
        n++; seen = 1'b1;
      end else if (seen && n < 16) begin
        gaps++;
      end
      if (done_b) break;
    end
    dv_b = 1'b0;
    chk("steady_addr_count", 64'(n), 64'(16));
    chk("steady_no_gaps", 64'(gaps), 64'(0));
    chk("credit_addr_seq", 64'(n_bad), 64'(0));
    chk("steady_done", 64'({done_b, busy_b, err_b}), 64'({1'b1, 1'b0, 1'b0}));

    base_a = AW'('h300); entry_a = 4; start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      tick();
      if (av_a) n++;
    end
    chk("mid_issued", 64'(n), 64'(5));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_reset_state", 64'({av_a, addr_a, uram_a, busy_a, done_a, err_a, cout_a}),
        64'({1'b0, AW'(0), 1'b0, 1'b0, 1'b0, 1'b0, 16'hffff}));
    dv_a = 1'b1; tick(); tick(); dv_a = 1'b0;
    chk("inflight_idle_no_err", 64'({err_a, busy_a}), 64'(0));

    run_a(AW'('h300), 2, 1'b0, -1, n_addr, n_bad, n_viol, n_uram, to);
    chk("reload_addr_count", 64'(n_addr), 64'(4));
    chk("reload_from_beat0", 64'(n_bad), 64'(0));
    chk("reload_done", 64'({to, err_a}), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/offset_load_ctrl.md
Name: offset_load_ctrl

Overview:
Sequences the bulk load of the vertex-offset table from one HBM pseudo channel into the per-core offset URAMs. On start it pulses the URAM write-pointer clear, then streams read addresses to the HBM controller with full-backpressure and an outstanding-beat credit limit. It counts returned beats and reports completion. It holds the cores in reset until the table is resident, so front-end offset reads never collide with load writes. It sits between the top-level launch logic and the offset URAM bank, one instance per pseudo channel.

Parameters:
HBM_AWIDTH, 28, HBM beat address width
CNT_WIDTH, 20, width of entry/beat counters
BEATS_PER_ENTRY, 2, HBM beats per URAM entry (loffset beat, roffset beat); must be 2
MAX_OUTSTANDING, 64, max issued-but-unreturned beats; power of two
OUT_WIDTH, 7, width of outstanding counter (log2(MAX_OUTSTANDING)+1)
CORE_NUM, 16, cores served by this pseudo channel
CLEAR_CYCLES, 2, uram_rst pulse length

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle load request
base_addr  in  HBM_AWIDTH  first beat address, sampled on accepted start
entry_num  in  CNT_WIDTH-1  URAM entries per core, sampled on accepted start
hbm_addr  out  HBM_AWIDTH  read beat address
hbm_addr_valid  out  1  hbm_addr valid this cycle
hbm_full  in  1  controller cannot accept an address this cycle
hbm_data_valid  in  1  one returned beat this cycle
uram_rst  out  1  clears URAM write pointers
load_busy  out  1  FSM not in IDLE/DONE
load_done  out  1  table resident; sticky until next accepted start or rst
protocol_err  out  1  sticky: beat returned while nothing outstanding
core_rst_in  in  CORE_NUM  per-core reset from launch logic
core_rst_out  out  CORE_NUM  registered core_rst_in | {CORE_NUM{~load_done}}

Behaviour:
- Reset values:
  - hbm_addr=0, hbm_addr_valid=0, uram_rst=0, load_busy=0, load_done=0, protocol_err=0.
  - core_rst_out=all ones. All counters 0. State=IDLE.
- States: IDLE, CLEAR, FETCH, DRAIN, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE; ignored otherwise.
  - Accept -> latch base_addr; total_beats = entry_num<<1; clear issued, received, outstanding; load_done<=0; go to CLEAR.
- CLEAR: uram_rst=1 for exactly CLEAR_CYCLES cycles, then go to FETCH. If total_beats==0, go to DONE instead.
- FETCH issue condition: issue = !hbm_full && outstanding<MAX_OUTSTANDING && issued<total_beats.
  - Registered output: the next cycle has hbm_addr_valid=1 and hbm_addr=base+issued. issued then increments.
  - If the condition fails, hbm_addr_valid=0 next cycle and hbm_addr holds its value.
  - Address sum wraps modulo 2^HBM_AWIDTH.
- Outstanding counter: +1 on issue, -1 on hbm_data_valid, unchanged when both happen together.
- Beat returned with outstanding==0: beat is ignored and not counted; protocol_err<=1.
- FETCH -> DRAIN when the last beat issues (issued reaches total_beats).
- DRAIN -> DONE in the cycle received reaches total_beats. load_done is 1 from the next cycle.
- DONE: load_done=1, load_busy=0. Beats arriving here set protocol_err.
- core_rst_out: one-cycle registered, as defined in Ports; stays all ones while loading.
- rst mid-load: immediate return to IDLE with reset values.
  - Beats still in flight afterwards are dropped and flagged only if they arrive after a new start.
  - The flag is not raised for beats arriving in IDLE.
- Latency: first hbm_addr_valid at cycle CLEAR_CYCLES+2 after the start cycle, given hbm_full low.

Decomposition:
- Shared package (accelerator header):
  - state encoding localparams.
  - BEATS_PER_ENTRY.
  - default widths, tied to existing V_OFF_AWIDTH / HBM_AWIDTH defines.
- One natural sub-module: offset_load_credit, the outstanding-beat up/down counter with limit compare and underflow flag.

Test Plan:
- Nominal: start, base=0x100, entry_num=4, hbm_full=0, beats returned 3 cycles after each address.
  - uram_rst high 2 cycles.
  - Addresses 0x100..0x107 issued back-to-back.
  - load_done rises 1 cycle after the 8th beat.
  - core_rst_out falls the following cycle.
- Backpressure: hbm_full high on alternate cycles, entry_num=8 -> no address issued in any cycle that follows a full cycle; 16 unique sequential addresses; done after 16 beats.
- Credit limit: MAX_OUTSTANDING=4, no data returned -> exactly 4 addresses issued, then hbm_addr_valid=0 until a beat returns, then one more address.
- Simultaneous issue and return every cycle at the limit -> outstanding stays constant; no address lost or duplicated.
- Edge cases:
  - entry_num=0: CLEAR then DONE, no addresses issued.
  - start during FETCH: ignored.
  - Stray beat in DONE: protocol_err=1.
- rst asserted mid-FETCH after 5 beats issued -> next cycle all outputs at reset values; a fresh start reloads from beat 0.
